// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
// fifo_wr_arbiter
//  Shares the single write port of the async FIFO write domain among NUM_REQ
//  requesters. A round-robin grant is taken in IDLE and held for a burst that
//  ends on req_last or after MAX_BURST accepted words. wr_full is honoured, so
//  the FIFO is never written past full. Everything runs in the wr_clk domain.
//
//  Ports
//   wr_clk     in   write-domain clock
//   wr_rst     in   asynchronous, active-low reset
//   req_valid  in   [NUM_REQ]            requester i has a word on req_data
//   req_last   in   [NUM_REQ]            word from requester i ends its burst
//   req_data   in   [NUM_REQ*DATA_SIZE]  requester i at [i*DATA_SIZE +: DATA_SIZE]
//   req_ready  out  [NUM_REQ]            word from requester i accepted (valid&ready)
//   wr_full    in   FIFO full flag (registered, write side)
//   wr_inc     out  write strobe to the FIFO
//   wr_data    out  [DATA_SIZE]          write data to the FIFO
//   gnt_id     out  [$clog2(NUM_REQ)]    currently granted requester
//   busy       out  high while a burst is granted
//
//  req_ready / wr_inc / wr_data are combinational from the registered state
//  and the granted requester's inputs, so the accept happens in the same
//  cycle the word is presented. They decode from state, so the asynchronous
//  reset forces them low without a clock edge.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                         wr_clk,
  input  logic                         wr_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wr_full,
  output logic                         wr_inc,
  output logic [DATA_SIZE-1:0]         wr_data,
  output logic [$clog2(NUM_REQ)-1:0]   gnt_id,
  output logic                         busy
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  // Count value at which the accepted word is the final one of a capped burst
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [GW-1:0] GNT_MAX  = GW'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [GW-1:0]        r_gnt_id;
  logic [GW-1:0]        r_rr_ptr;
  logic [CW-1:0]        r_burst_cnt;

  logic [GW-1:0]        w_arb_pick;
  logic [GW-1:0]        w_arb_idx;
  logic                 w_arb_found;
  logic [GW-1:0]        w_gnt_inc;
  logic                 w_any_req;
  logic                 w_accept;
  logic                 w_burst_end;
  logic [DATA_SIZE-1:0] w_req_word [NUM_REQ];

  // Unpack the flat request data bus into one word per requester
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_word[gi] = req_data[gi*DATA_SIZE +: DATA_SIZE];
  end

  assign w_any_req = |req_valid;

  // A word moves only while bursting, the granted requester offers one and
  // the FIFO has room
  assign w_accept    = (r_state == S_BURST) && req_valid[r_gnt_id] && !wr_full;
  assign w_burst_end = w_accept && (req_last[r_gnt_id] || (r_burst_cnt == CNT_LAST));

  // Pointer for the next arbitration: one past the requester just served
  assign w_gnt_inc = (r_gnt_id == GNT_MAX) ? '0 : r_gnt_id + GW'(1);

  // Round-robin search: first valid requester starting at r_rr_ptr, wrapping
  always_comb begin
    w_arb_pick  = r_rr_ptr;
    w_arb_idx   = r_rr_ptr;
    w_arb_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_arb_idx = GW'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_arb_found && req_valid[w_arb_idx]) begin
        w_arb_pick  = w_arb_idx;
        w_arb_found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (w_burst_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready = '0;
    wr_inc    = 1'b0;
    wr_data   = '0;
    busy      = (r_state == S_BURST);
    gnt_id    = r_gnt_id;
    if (r_state == S_BURST) begin
      req_ready[r_gnt_id] = !wr_full;
      wr_inc              = w_accept;
      if (w_accept) begin
        wr_data = w_req_word[r_gnt_id];
      end
    end
  end

  // Grant, round-robin pointer and burst word counter
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      r_gnt_id    <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_any_req) begin
        r_gnt_id    <= w_arb_pick;
        r_burst_cnt <= '0;
      end else if (w_accept) begin
        if (w_burst_end) begin
          r_rr_ptr    <= w_gnt_inc;
          r_burst_cnt <= '0;
        end else begin
          r_burst_cnt <= r_burst_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
// tb_fifo_wr_arbiter
//  Directed scenarios (reset, round robin, burst cap, full stall, valid gap)
//  followed by a randomized run checked against a transaction-level model of
//  the arbitration rules and a per-requester word-order scoreboard.
module tb_fifo_wr_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned DATA_SIZE = 8;
  localparam int unsigned MAX_BURST = 8;
  localparam int unsigned GW        = $clog2(NUM_REQ);
  localparam int          NR        = 4;
  localparam int          MB        = 8;

  logic                         wr_clk = 1'b0;
  logic                         wr_rst;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         wr_full;
  logic                         wr_inc;
  logic [DATA_SIZE-1:0]         wr_data;
  logic [GW-1:0]                gnt_id;
  logic                         busy;

  int n_tests;
  int n_fail;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_SIZE(DATA_SIZE),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .wr_clk   (wr_clk),
    .wr_rst   (wr_rst),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_data (req_data),
    .req_ready(req_ready),
    .wr_full  (wr_full),
    .wr_inc   (wr_inc),
    .wr_data  (wr_data),
    .gnt_id   (gnt_id),
    .busy     (busy)
  );

  task automatic set_word(input int i, input logic [DATA_SIZE-1:0] d);
    req_data[i*DATA_SIZE +: DATA_SIZE] = d;
  endtask

  // Advance to just after the next rising edge, where inputs are driven
  task automatic next_cycle();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    wr_rst    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wr_full   = 1'b0;
    @(posedge wr_clk);
    @(posedge wr_clk);
    #1 wr_rst = 1'b1;
  endtask

  task automatic test_reset();
    wr_rst    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wr_full   = 1'b0;
    #2;
    n_tests++;
    if ({busy, wr_inc, req_ready, gnt_id, wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got busy=%b inc=%b ready=%b gnt=%0d data=%h, want all 0",
               busy, wr_inc, req_ready, gnt_id, wr_data);
    end
    @(posedge wr_clk);
    #1 wr_rst = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int i = 0; i < NR; i++) set_word(i, 8'hA0 + 8'(i));
    repeat (3) next_cycle();
    #1;
    n_tests++;
    if ({busy, gnt_id} !== {1'b1, GW'(1)}) begin
      n_fail++;
      $display("FAIL pre_reset_burst: got busy=%b gnt=%0d, want busy=1 gnt=1", busy, gnt_id);
    end
    #1 wr_rst = 1'b0;
    #1;
    n_tests++;
    if ({busy, wr_inc, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_burst: got busy=%b inc=%b ready=%b, want 0", busy, wr_inc, req_ready);
    end
    @(posedge wr_clk);
    #1 wr_rst = 1'b1;
    @(negedge wr_clk);
    n_tests++;
    if ({busy, wr_inc} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%b inc=%b, want 0", busy, wr_inc);
    end
    next_cycle();
    @(negedge wr_clk);
    n_tests++;
    if ({busy, gnt_id, wr_inc, wr_data} !== {1'b1, GW'(0), 1'b1, 8'hA0}) begin
      n_fail++;
      $display("FAIL first_grant: got busy=%b gnt=%0d inc=%b data=%h, want 1 0 1 a0",
               busy, gnt_id, wr_inc, wr_data);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [GW-1:0]      eg;
    logic [NUM_REQ-1:0] er;
    int                 n_inc;
    do_reset();
    n_inc     = 0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int i = 0; i < NR; i++) set_word(i, 8'hA0 + 8'(i));
    for (int c = 0; c < 10; c++) begin
      @(negedge wr_clk);
      if (wr_inc) n_inc++;
      n_tests++;
      if (c % 2 == 0) begin
        if ({busy, wr_inc, req_ready} !== '0) begin
          n_fail++;
          $display("FAIL rr_gap c%0d: got busy=%b inc=%b ready=%b, want 0", c, busy, wr_inc, req_ready);
        end
      end else begin
        eg = GW'((c / 2) % NR);
        er = NUM_REQ'(1) << eg;
        if ({busy, gnt_id, wr_inc, wr_data, req_ready} !== {1'b1, eg, 1'b1, 8'hA0 + 8'(eg), er}) begin
          n_fail++;
          $display("FAIL rr_grant c%0d: got gnt=%0d inc=%b data=%h ready=%b, want gnt=%0d data=%h ready=%b",
                   c, gnt_id, wr_inc, wr_data, req_ready, eg, 8'hA0 + 8'(eg), er);
        end
      end
      next_cycle();
    end
    n_tests++;
    if (n_inc != 5) begin
      n_fail++;
      $display("FAIL rr_inc_count: got %0d, want 5", n_inc);
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic test_burst_cap();
    int widx, n_inc, gaps, exp_idx;
    bit exp_inc, acc;
    do_reset();
    widx  = 0;
    n_inc = 0;
    gaps  = 0;
    for (int c = 0; c < 24; c++) begin
      req_valid = (widx < 20) ? 4'b0100 : 4'b0000;
      req_last  = (widx == 19) ? 4'b0100 : 4'b0000;
      set_word(2, 8'h10 + 8'(widx));
      @(negedge wr_clk);
      // Bursts of 8, 8, 4, each preceded by one arbitration cycle
      exp_inc = (c < 23) && (c % 9 != 0);
      exp_idx = c - c / 9 - 1;
      n_tests++;
      if (wr_inc !== exp_inc) begin
        n_fail++;
        $display("FAIL cap_inc c%0d: got %b, want %b", c, wr_inc, exp_inc);
      end
      if (exp_inc) begin
        n_tests++;
        if ({gnt_id, wr_data} !== {GW'(2), 8'h10 + 8'(exp_idx)}) begin
          n_fail++;
          $display("FAIL cap_data c%0d: got gnt=%0d data=%h, want gnt=2 data=%h",
                   c, gnt_id, wr_data, 8'h10 + 8'(exp_idx));
        end
      end
      if (wr_inc) n_inc++;
      if (!busy && n_inc > 0 && n_inc < 20) gaps++;
      acc = wr_inc && req_ready[2];
      next_cycle();
      if (acc) widx++;
    end
    n_tests++;
    if (n_inc != 20 || gaps != 2) begin
      n_fail++;
      $display("FAIL cap_totals: got writes=%0d gaps=%0d, want 20 and 2", n_inc, gaps);
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic test_full_stall();
    int widx, exp_idx;
    bit exp_inc, acc;
    do_reset();
    widx = 0;
    for (int c = 0; c < 13; c++) begin
      req_valid = (widx < 6) ? 4'b0010 : 4'b0000;
      req_last  = (widx == 5) ? 4'b0010 : 4'b0000;
      set_word(1, 8'h30 + 8'(widx));
      wr_full = (c >= 3 && c <= 7);
      @(negedge wr_clk);
      exp_inc = (c >= 1 && c <= 2) || (c >= 8 && c <= 11);
      exp_idx = (c <= 2) ? c - 1 : c - 6;
      n_tests++;
      if (wr_inc !== exp_inc) begin
        n_fail++;
        $display("FAIL stall_inc c%0d: got %b, want %b", c, wr_inc, exp_inc);
      end
      if (exp_inc) begin
        n_tests++;
        if ({gnt_id, wr_data} !== {GW'(1), 8'h30 + 8'(exp_idx)}) begin
          n_fail++;
          $display("FAIL stall_data c%0d: got gnt=%0d data=%h, want gnt=1 data=%h",
                   c, gnt_id, wr_data, 8'h30 + 8'(exp_idx));
        end
      end
      if (wr_full) begin
        n_tests++;
        if ({busy, gnt_id, req_ready} !== {1'b1, GW'(1), 4'b0000}) begin
          n_fail++;
          $display("FAIL stall_hold c%0d: got busy=%b gnt=%0d ready=%b, want 1 1 0000",
                   c, busy, gnt_id, req_ready);
        end
      end
      acc = wr_inc && req_ready[1];
      next_cycle();
      if (acc) widx++;
    end
    req_valid = '0;
    req_last  = '0;
    wr_full   = 1'b0;
  endtask

  task automatic test_valid_gap();
    int                   widx;
    bit                   exp_inc, acc;
    logic [DATA_SIZE-1:0] exp_data;
    do_reset();
    widx = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid[0] = (widx < 6) && !(c >= 3 && c <= 5);
      req_last[0]  = (widx == 5);
      set_word(0, 8'h50 + 8'(widx));
      req_valid[1] = 1'b1;
      req_last[1]  = 1'b1;
      set_word(1, 8'h61);
      @(negedge wr_clk);
      exp_inc  = (c == 1) || (c == 2) || (c >= 6 && c <= 9) || (c == 11);
      exp_data = (c == 11) ? 8'h61 : 8'h50 + 8'((c <= 2) ? c - 1 : c - 4);
      n_tests++;
      if (wr_inc !== exp_inc) begin
        n_fail++;
        $display("FAIL gap_inc c%0d: got %b, want %b", c, wr_inc, exp_inc);
      end
      if (exp_inc) begin
        n_tests++;
        if (wr_data !== exp_data) begin
          n_fail++;
          $display("FAIL gap_data c%0d: got %h, want %h", c, wr_data, exp_data);
        end
      end
      if (c >= 1 && c <= 9) begin
        n_tests++;
        if ({busy, gnt_id, req_ready[1]} !== {1'b1, GW'(0), 1'b0}) begin
          n_fail++;
          $display("FAIL gap_hold c%0d: got busy=%b gnt=%0d ready1=%b, want 1 0 0",
                   c, busy, gnt_id, req_ready[1]);
        end
      end
      if (c == 10 || c == 11) begin
        n_tests++;
        if ({busy, gnt_id} !== ((c == 10) ? {1'b0, gnt_id} : {1'b1, GW'(1)})) begin
          n_fail++;
          $display("FAIL gap_regrant c%0d: got busy=%b gnt=%0d", c, busy, gnt_id);
        end
      end
      acc = wr_inc && req_ready[0];
      next_cycle();
      if (acc) widx++;
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic test_random();
    int                 exp_seq [NR];
    int                 seq     [NR];
    int                 waits   [NR];
    int                 writes  [NR];
    bit                 m_busy;
    bit                 m_acc;
    int                 m_gnt, m_rr, m_cnt, pick;
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] acc;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      exp_seq[i] = 0;
      seq[i]     = 0;
      waits[i]   = 0;
      writes[i]  = 0;
    end
    m_busy = 1'b0;
    m_gnt  = 0;
    m_rr   = 0;
    m_cnt  = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      // Requesters hold a word stable until it is taken
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 99) < 45) begin
          req_valid[i] = 1'b1;
          req_last[i]  = ($urandom_range(0, 3) == 0);
          set_word(i, {2'(i), 6'(seq[i])});
        end
      end
      wr_full = ($urandom_range(0, 99) < 20);
      @(negedge wr_clk);
      m_acc = 1'b0;
      n_tests++;
      if (m_busy) begin
        m_acc     = req_valid[m_gnt] && !wr_full;
        exp_ready = wr_full ? '0 : NUM_REQ'(1) << m_gnt;
        if ({busy, gnt_id, wr_inc, req_ready} !== {1'b1, GW'(m_gnt), m_acc, exp_ready}) begin
          n_fail++;
          $display("FAIL rnd_burst cyc%0d: got busy=%b gnt=%0d inc=%b ready=%b, want 1 %0d %b %b",
                   cyc, busy, gnt_id, wr_inc, req_ready, m_gnt, m_acc, exp_ready);
        end
        if (m_acc) begin
          n_tests++;
          if (wr_data !== {2'(m_gnt), 6'(exp_seq[m_gnt])}) begin
            n_fail++;
            $display("FAIL rnd_order cyc%0d: got data=%h, want %h",
                     cyc, wr_data, {2'(m_gnt), 6'(exp_seq[m_gnt])});
          end
        end
      end else begin
        if ({busy, wr_inc, req_ready, wr_data} !== '0) begin
          n_fail++;
          $display("FAIL rnd_idle cyc%0d: got busy=%b inc=%b ready=%b data=%h, want 0",
                   cyc, busy, wr_inc, req_ready, wr_data);
        end
      end
      if (wr_full) begin
        n_tests++;
        if (wr_inc !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_full_write cyc%0d: got wr_inc=%b, want 0", cyc, wr_inc);
        end
      end
      acc = req_valid & req_ready;
      // Model: arbitrate from the round-robin pointer, or count the accept
      if (!m_busy) begin
        if (|req_valid) begin
          pick = -1;
          for (int k = 0; k < NR; k++) begin
            if (pick < 0 && req_valid[(m_rr + k) % NR]) pick = (m_rr + k) % NR;
          end
          for (int i = 0; i < NR; i++) begin
            if (i != pick && req_valid[i]) begin
              waits[i]++;
              n_tests++;
              if (waits[i] >= NR) begin
                n_fail++;
                $display("FAIL rnd_starve cyc%0d: req %0d passed over %0d bursts, want < %0d",
                         cyc, i, waits[i], NR);
              end
            end
          end
          waits[pick] = 0;
          m_gnt  = pick;
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end else if (m_acc) begin
        exp_seq[m_gnt]++;
        writes[m_gnt]++;
        m_cnt++;
        if (req_last[m_gnt] || m_cnt == MB) begin
          m_busy = 1'b0;
          m_rr   = (m_gnt + 1) % NR;
        end
      end
      next_cycle();
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          req_valid[i] = 1'b0;
          seq[i]++;
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      n_tests++;
      if (writes[i] == 0) begin
        n_fail++;
        $display("FAIL rnd_served req%0d: got 0 writes, want > 0", i);
      end
    end
    req_valid = '0;
    req_last  = '0;
    wr_full   = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_round_robin();
    test_burst_cap();
    test_full_stall();
    test_valid_gap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
